// File: rtl/mc_datapath.sv
// Multi-cycle datapath: IDLE -> EXEC -> (MEM) -> WB, one instruction in flight at a time.
// Holds a register file (x0 hardwired to zero) and a small data memory, both cleared by reset.
// Build option MC_DATAPATH_PERF_EN: when defined, retired_cnt counts completed WB cycles;
// otherwise retired_cnt is tied to zero.
module mc_datapath #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned DM_DEPTH = 32,
  localparam int unsigned RW      = $clog2(NREGS),
  localparam int unsigned AW      = $clog2(DM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  input  logic [RW-1:0]   rd,
  input  logic [3:0]      alu_op,
  input  logic            use_imm,
  input  logic [XLEN-1:0] imm,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            is_lui,
  input  logic            br_en,
  input  logic [1:0]      br_type,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            br_taken,
  output logic [AW-1:0]   dm_addr,
  output logic [31:0]     retired_cnt
);

  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StExec, StMem, StWb} state_e;

  state_e          state_q;
  logic [RW-1:0]   rs1_q, rs2_q, rd_q;
  logic [3:0]      alu_op_q;
  logic            use_imm_q;
  logic [XLEN-1:0] imm_q;
  logic            load_q, store_q, lui_q, br_en_q;
  logic [1:0]      br_type_q;
  logic            out_valid_q, br_taken_q;
  logic [XLEN-1:0] result_q;
  logic [AW-1:0]   dm_addr_q;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] mem_q  [DM_DEPTH];

  logic            single_cls;
  logic [XLEN-1:0] rs1_val, rs2_val, op_b, alu_res;
  logic [SW-1:0]   shamt;
  logic            br_cond, is_branch, rd_we;
  logic [AW-1:0]   mem_addr;

  // More than one class flag set falls back to a plain ALU instruction.
  assign single_cls = $onehot({is_load, is_store, is_lui});

  assign rs1_val   = regs_q[rs1_q];
  assign rs2_val   = regs_q[rs2_q];
  assign op_b      = use_imm_q ? imm_q : rs2_val;
  assign shamt     = op_b[SW-1:0];
  assign mem_addr  = AW'(rs1_val + imm_q);
  assign is_branch = br_en_q & ~load_q & ~store_q & ~lui_q;
  assign rd_we     = ~store_q & ~is_branch;

  // ALU: opcodes 10..15 alias to ADD.
  always_comb begin
    alu_res = rs1_val + op_b;
    case (alu_op_q)
      4'd1:    alu_res = rs1_val - op_b;
      4'd2:    alu_res = rs1_val & op_b;
      4'd3:    alu_res = rs1_val | op_b;
      4'd4:    alu_res = rs1_val ^ op_b;
      4'd5:    alu_res = rs1_val << shamt;
      4'd6:    alu_res = rs1_val >> shamt;
      4'd7:    alu_res = XLEN'($signed(rs1_val) >>> shamt);
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, rs1_val < op_b};
      default: alu_res = rs1_val + op_b;
    endcase
  end

  // Branch compare always uses register data, never the immediate.
  always_comb begin
    case (br_type_q)
      2'd0:    br_cond = (rs1_val == rs2_val);
      2'd1:    br_cond = (rs1_val != rs2_val);
      2'd2:    br_cond = ($signed(rs1_val) < $signed(rs2_val));
      default: br_cond = ($signed(rs1_val) >= $signed(rs2_val));
    endcase
  end

  // Sequencer: latches the instruction, computes results and drives registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      use_imm_q   <= 1'b0;
      imm_q       <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      lui_q       <= 1'b0;
      br_en_q     <= 1'b0;
      br_type_q   <= '0;
      out_valid_q <= 1'b0;
      br_taken_q  <= 1'b0;
      result_q    <= '0;
      dm_addr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            rs1_q     <= rs1;
            rs2_q     <= rs2;
            rd_q      <= rd;
            alu_op_q  <= alu_op;
            use_imm_q <= use_imm;
            imm_q     <= imm;
            load_q    <= is_load & single_cls;
            store_q   <= is_store & single_cls;
            lui_q     <= is_lui & single_cls;
            br_en_q   <= br_en;
            br_type_q <= br_type;
            state_q   <= StExec;
          end
        end
        StExec: begin
          if (load_q || store_q) begin
            state_q <= StMem;
          end else begin
            result_q    <= lui_q ? imm_q : (is_branch ? '0 : alu_res);
            br_taken_q  <= is_branch & br_cond;
            out_valid_q <= 1'b1;
            state_q     <= StWb;
          end
        end
        StMem: begin
          dm_addr_q   <= mem_addr;
          result_q    <= load_q ? mem_q[mem_addr] : XLEN'(mem_addr);
          br_taken_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StWb;
        end
        StWb: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Architectural storage: store commits at end of MEM, register write at end of WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      for (int unsigned j = 0; j < DM_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      if (state_q == StMem && store_q) mem_q[mem_addr] <= rs2_val;
      if (state_q == StWb && rd_we && rd_q != '0) regs_q[rd_q] <= result_q;
    end
  end

`ifdef MC_DATAPATH_PERF_EN
  logic [31:0] retired_q;

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (state_q == StWb) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
`else
  assign retired_cnt = '0;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign br_taken  = br_taken_q;
  assign dm_addr   = dm_addr_q;

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter XLEN, default 32, data and register width in bits (8..64).
REQ-002 Parameter NREGS, default 32, register-file entries (power of two, >=2); RW = clog2(NREGS).
REQ-003 Parameter DM_DEPTH, default 32, data-memory words (power of two); AW = clog2(DM_DEPTH).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  decoded instruction present on the in_* and control inputs.
REQ-007 in_ready  out  1  block can accept an instruction.
REQ-008 rs1, rs2  in  RW each  source register indices.
REQ-009 rd  in  RW  destination register index.
REQ-010 alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU; 10-15 ADD.
REQ-011 use_imm  in  1  operand B = imm instead of rs2 data.
REQ-012 imm  in  XLEN  immediate, already extended.
REQ-013 is_load, is_store, is_lui  in  1 each  operation class; at most one high, else the instruction is treated as ALU.
REQ-014 br_en  in  1, br_type  in  2  branch compare: 0 BEQ, 1 BNE, 2 BLT (signed), 3 BGE (signed).
REQ-015 out_valid  out  1  one-cycle completion pulse.
REQ-016 result  out  XLEN  written-back value, or store address for stores.
REQ-017 br_taken  out  1  branch outcome, qualified by out_valid.
REQ-018 dm_addr  out  AW  last memory address used.
REQ-019 retired_cnt  out  32  retired-instruction count (see Configuration).

Function
REQ-020 FSM states IDLE, EXEC, MEM, WB; in_ready = 1 only in IDLE.
REQ-021 Accept on in_valid && in_ready; all inputs latched at the accepting edge; IDLE -> EXEC.
REQ-022 EXEC: operands read from the register file; result computed; -> MEM if load/store, else -> WB.
REQ-023 MEM: address = (rs1 + imm)[AW-1:0], wrapping modulo DM_DEPTH; store writes rs2 data at the end of MEM; load data is latched; -> WB.
REQ-024 WB: out_valid = 1 for exactly this cycle; rd is written at the end of WB for ALU, LUI and load; -> IDLE.
REQ-025 Latency: out_valid is high in the 2nd cycle after the accepting edge (non-memory) or the 3rd (load/store); throughput is one instruction per 3 or 4 cycles.
REQ-026 Register 0 always reads 0; writes to it are discarded.
REQ-027 Shifts use operand B[clog2(XLEN)-1:0]; ADD/SUB wrap modulo 2^XLEN; SLT/SLTU produce 0 or 1.
REQ-028 LUI result = imm; rs1 ignored.
REQ-029 Branch: no register write; result = 0; br_taken from the compare of rs1 and rs2 data; br_taken = 0 when br_en = 0.
REQ-030 Store: no register write; result = {0, address}.
REQ-031 Register reads in EXEC see every write from previous instructions; no hazard stall is needed.
REQ-032 br_taken, result and dm_addr hold their values until the next WB.

Reset
REQ-033 rst low forces IDLE immediately, from any state, aborting any instruction in flight without a register or memory write.
REQ-034 Reset values: all registers 0; all memory words 0; out_valid, br_taken, result, dm_addr and retired_cnt 0; in_ready 1 once reset is released.

Configuration
REQ-035 Macro MC_DATAPATH_PERF_EN defined: retired_cnt increments by 1 at the end of every WB and wraps from 2^32-1 to 0.
REQ-036 Macro MC_DATAPATH_PERF_EN undefined: no counter logic; retired_cnt is constant 0; the port is still present.

Verification
REQ-037 Reset, then ADD x1 = x0 + imm 5 (use_imm) -> out_valid 2 cycles after accept, result 5, x1 = 5.
REQ-038 x1 = 5, store rs1 = x0, rs2 = x1, imm 33 (DM_DEPTH 32), then load x2 with imm 1 -> dm_addr 1 for both, x2 = 5, store result 1.
REQ-039 x1 = 5, x3 = -1: BLT rs1 = x3, rs2 = x1 -> br_taken 1; BGE with the same operands -> br_taken 0; no register changes.
REQ-040 ADD rd = x0 with imm 7 -> result 7, x0 still reads 0; SRA of 0x80000000 by 33 -> 0xC0000000.
REQ-041 rst pulsed low during MEM of a store -> memory word unchanged, state IDLE, out_valid never pulses.
REQ-042 PERF_EN build: 3 instructions retired -> retired_cnt 3; non-PERF build -> retired_cnt stays 0.
